// File: rtl/pipe_control_unit.sv
// pipe_control_unit
//   Pipelined RV32I control decoder. Decodes a 32-bit instruction, carries
//   the control bundle through PIPE_DEPTH registered stages, and runs a
//   run/halt/pause/trap FSM that gates PC advance. It also keeps a saturating
//   count of accepted instructions.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   instr, in_valid          instruction from fetch and its valid flag
//   stall                    hold every stage; nothing is accepted
//   flush                    turn every stage into a bubble (wins over stall)
//   resume                   single-cycle pulse that leaves PAUSE
//   branch .. mux_rd1_pc     control bundle from the last stage
//   mem_to_reg, alu_op       2-bit writeback select and ALU class
//   ctrl_valid               last stage holds a real instruction
//   pc_load                  fetch may advance the PC this cycle
//   halted, paused, trap     registered FSM state flags
//   retired                  saturating count of accepted instructions
module pipe_control_unit #(
   parameter int unsigned PIPE_DEPTH      = 1,
   parameter bit          HALT_ON_EBREAK  = 1'b1,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic             resume,
   output logic             branch,
   output logic             mem_read,
   output logic             mem_write,
   output logic             alu_src,
   output logic             reg_write,
   output logic             mux_rd1_pc,
   output logic [1:0]       mem_to_reg,
   output logic [1:0]       alu_op,
   output logic             ctrl_valid,
   output logic             pc_load,
   output logic             halted,
   output logic             paused,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   // Stage word: {valid, branch, mem_read, mem_to_reg[1:0], alu_op[1:0],
   //              mem_write, alu_src, reg_write, mux_rd1_pc}
   localparam int unsigned BW = 11;

   typedef enum logic [1:0] {StRun, StHalt, StPause, StTrap} state_e;

   state_e           state_q, state_d;
   logic [9:0]       dec;
   logic             legal;
   logic             is_system;
   logic             is_ecall;
   logic             is_ebreak;
   logic             accept;
   logic [BW-1:0]    stage_in;
   logic [PIPE_DEPTH-1:0][BW-1:0] stage_q, stage_d;
   logic             halted_q, paused_q, trap_q;
   logic [CNT_W-1:0] retired_q;

   // Only the opcode and the ECALL/EBREAK discriminator are decoded.
   logic unused_instr;
   assign unused_instr = ^{instr[31:21], instr[19:7]};

   // ------------------------------------------------------------------
   // Decode: every field gets a default, so nothing is ever held.
   // ------------------------------------------------------------------
   always_comb begin
      dec       = '0;
      legal     = 1'b0;
      is_system = 1'b0;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:2])
            5'b11000: begin legal = 1'b1; dec = 10'b1_0_00_01_0_1_0_0; end // BRANCH
            5'b00000: begin legal = 1'b1; dec = 10'b0_1_00_00_0_1_1_1; end // LOAD
            5'b01000: begin legal = 1'b1; dec = 10'b0_0_00_00_1_1_0_1; end // STORE
            5'b11001: begin legal = 1'b1; dec = 10'b1_0_01_11_0_1_1_1; end // JALR
            5'b11011: begin legal = 1'b1; dec = 10'b1_0_01_00_0_0_1_1; end // JAL
            5'b01100: begin legal = 1'b1; dec = 10'b0_0_11_10_0_1_1_0; end // OP
            5'b00100: begin legal = 1'b1; dec = 10'b0_0_11_11_0_1_1_1; end // OP-IMM
            5'b00101: begin legal = 1'b1; dec = 10'b0_0_11_00_0_0_1_1; end // AUIPC
            5'b01101: begin legal = 1'b1; dec = 10'b0_0_10_00_0_0_1_0; end // LUI
            5'b11100: begin legal = 1'b1; is_system = 1'b1; end           // SYSTEM
            5'b00011: begin legal = 1'b1; end                             // MISC-MEM
            default:  begin legal = 1'b0; end
         endcase
      end
   end

   assign is_ecall  = is_system & ~instr[20];
   assign is_ebreak = is_system &  instr[20];

   assign accept = in_valid & ~stall & ~flush & (state_q == StRun);

   // ------------------------------------------------------------------
   // FSM next state; transitions out of RUN happen only on accept.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (accept) begin
               if (!legal) begin
                  if (TRAP_ON_ILLEGAL) state_d = StTrap;
               end else if (is_ecall) begin
                  state_d = StHalt;
               end else if (is_ebreak && HALT_ON_EBREAK) begin
                  state_d = StPause;
               end
            end
         end
         StPause: begin
            if (resume) state_d = StRun;
         end
         default: state_d = state_q; // HALT and TRAP leave only through rst
      endcase
   end

   // Drops in the very cycle the halting instruction is accepted.
   assign pc_load = (state_q == StRun) & ~(accept & (state_d != StRun));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StRun;
         halted_q  <= 1'b0;
         paused_q  <= 1'b0;
         trap_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == StHalt);
         paused_q <= (state_d == StPause);
         trap_q   <= (state_d == StTrap);
         if (accept && (retired_q != {CNT_W{1'b1}})) begin
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // ------------------------------------------------------------------
   // Control pipeline. Illegal instructions enter as bubbles; halting
   // instructions enter as valid all-zero bundles.
   // ------------------------------------------------------------------
   assign stage_in   = (accept && legal) ? {1'b1, dec} : '0;
   assign stage_d[0] = stage_in;

   for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_stage
      assign stage_d[k] = stage_q[k-1];
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         stage_q <= '0;
      end else if (!stall) begin
         stage_q <= stage_d;
      end
   end

   assign {ctrl_valid, branch, mem_read, mem_to_reg, alu_op,
           mem_write, alu_src, reg_write, mux_rd1_pc} = stage_q[PIPE_DEPTH-1];

   assign halted  = halted_q;
   assign paused  = paused_q;
   assign trap    = trap_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench: instance a uses PIPE_DEPTH=2 with halt/trap enabled,
// instance b uses PIPE_DEPTH=1, EBREAK as NOP, illegal as bubble, CNT_W=4.
module tb_pipe_control_unit;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        in_valid;
   logic        stall;
   logic        flush;
   logic        resume;

   logic a_branch, a_mem_read, a_mem_write, a_alu_src, a_reg_write, a_mux_rd1_pc;
   logic [1:0] a_mem_to_reg, a_alu_op;
   logic a_ctrl_valid, a_pc_load, a_halted, a_paused, a_trap;
   logic [15:0] a_retired;

   logic b_branch, b_mem_read, b_mem_write, b_alu_src, b_reg_write, b_mux_rd1_pc;
   logic [1:0] b_mem_to_reg, b_alu_op;
   logic b_ctrl_valid, b_pc_load, b_halted, b_paused, b_trap;
   logic [3:0] b_retired;

   logic [9:0] a_bun, b_bun;
   assign a_bun = {a_branch, a_mem_read, a_mem_to_reg, a_alu_op,
                   a_mem_write, a_alu_src, a_reg_write, a_mux_rd1_pc};
   assign b_bun = {b_branch, b_mem_read, b_mem_to_reg, b_alu_op,
                   b_mem_write, b_alu_src, b_reg_write, b_mux_rd1_pc};

   int total;
   int bad;

   pipe_control_unit #(
      .PIPE_DEPTH(2), .HALT_ON_EBREAK(1'b1), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(16)
   ) u_a (
      .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .stall(stall),
      .flush(flush), .resume(resume), .branch(a_branch), .mem_read(a_mem_read),
      .mem_write(a_mem_write), .alu_src(a_alu_src), .reg_write(a_reg_write),
      .mux_rd1_pc(a_mux_rd1_pc), .mem_to_reg(a_mem_to_reg), .alu_op(a_alu_op),
      .ctrl_valid(a_ctrl_valid), .pc_load(a_pc_load), .halted(a_halted),
      .paused(a_paused), .trap(a_trap), .retired(a_retired)
   );

   pipe_control_unit #(
      .PIPE_DEPTH(1), .HALT_ON_EBREAK(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)
   ) u_b (
      .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .stall(stall),
      .flush(flush), .resume(resume), .branch(b_branch), .mem_read(b_mem_read),
      .mem_write(b_mem_write), .alu_src(b_alu_src), .reg_write(b_reg_write),
      .mux_rd1_pc(b_mux_rd1_pc), .mem_to_reg(b_mem_to_reg), .alu_op(b_alu_op),
      .ctrl_valid(b_ctrl_valid), .pc_load(b_pc_load), .halted(b_halted),
      .paused(b_paused), .trap(b_trap), .retired(b_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; resume = 1'b0;
      instr = 32'h0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; instr = 32'h00A50533; stall = 1'b0;
      flush = 1'b0; resume = 1'b1;
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0; resume = 1'b0;
      #1;
      total++; if (a_ctrl_valid !== 1'b0) begin bad++;
         $display("FAIL reset_valid got=%0b want=0", a_ctrl_valid); end
      total++; if (a_bun !== 10'b0) begin bad++;
         $display("FAIL reset_bundle got=%b want=0", a_bun); end
      total++; if (a_retired !== 16'd0) begin bad++;
         $display("FAIL reset_retired got=%0d want=0", a_retired); end
      total++; if ({a_halted, a_paused, a_trap} !== 3'b000) begin bad++;
         $display("FAIL reset_flags got=%b want=000", {a_halted, a_paused, a_trap}); end
      total++; if (a_pc_load !== 1'b1) begin bad++;
         $display("FAIL reset_pc_load got=%0b want=1", a_pc_load); end
   endtask

   task automatic test_add;
      do_reset();
      instr = 32'h00A50533; in_valid = 1'b1;
      #1;
      total++; if (a_pc_load !== 1'b1) begin bad++;
         $display("FAIL add_pc_load got=%0b want=1", a_pc_load); end
      tick();
      in_valid = 1'b0;
      total++; if (a_ctrl_valid !== 1'b0) begin bad++;
         $display("FAIL add_early got=%0b want=0", a_ctrl_valid); end
      total++; if ({b_ctrl_valid, b_bun} !== {1'b1, 10'b0_0_11_10_0_1_1_0}) begin bad++;
         $display("FAIL add_b_bundle got=%b want=1_0011100110", {b_ctrl_valid, b_bun}); end
      tick();
      total++; if ({a_ctrl_valid, a_bun} !== {1'b1, 10'b0_0_11_10_0_1_1_0}) begin bad++;
         $display("FAIL add_a_bundle got=%b want=1_0011100110", {a_ctrl_valid, a_bun}); end
      total++; if (a_retired !== 16'd1) begin bad++;
         $display("FAIL add_retired got=%0d want=1", a_retired); end
      tick();
      total++; if (a_ctrl_valid !== 1'b0) begin bad++;
         $display("FAIL add_drain got=%0b want=0", a_ctrl_valid); end
   endtask

   task automatic test_load_stall;
      do_reset();
      instr = 32'h0002A303; in_valid = 1'b1;
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (a_ctrl_valid !== 1'b0 || a_retired !== 16'd1) begin bad++;
            $display("FAIL stall_a_frozen got=v%0b r%0d want=v0 r1", a_ctrl_valid, a_retired); end
         total++; if ({b_ctrl_valid, b_mem_read} !== 2'b11) begin bad++;
            $display("FAIL stall_b_frozen got=%b want=11", {b_ctrl_valid, b_mem_read}); end
      end
      stall = 1'b0; in_valid = 1'b0;
      tick();
      total++; if ({a_ctrl_valid, a_bun} !== {1'b1, 10'b0_1_00_00_0_1_1_1}) begin bad++;
         $display("FAIL load_bundle got=%b want=1_0100000111", {a_ctrl_valid, a_bun}); end
      total++; if (a_retired !== 16'd1) begin bad++;
         $display("FAIL load_retired got=%0d want=1", a_retired); end
   endtask

   task automatic test_flush;
      do_reset();
      instr = 32'h0062A023; in_valid = 1'b1;
      tick();
      total++; if ({b_ctrl_valid, b_bun} !== {1'b1, 10'b0_0_00_00_1_1_0_1}) begin bad++;
         $display("FAIL store_b_bundle got=%b want=1_0000001101", {b_ctrl_valid, b_bun}); end
      flush = 1'b1; stall = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      total++; if (a_ctrl_valid !== 1'b0 || b_ctrl_valid !== 1'b0) begin bad++;
         $display("FAIL flush_out got=a%0b b%0b want=a0 b0", a_ctrl_valid, b_ctrl_valid); end
      total++; if (a_retired !== 16'd1) begin bad++;
         $display("FAIL flush_retired got=%0d want=1", a_retired); end
      tick();
      total++; if (a_ctrl_valid !== 1'b0 || a_mem_write !== 1'b0) begin bad++;
         $display("FAIL flush_killed got=v%0b w%0b want=v0 w0", a_ctrl_valid, a_mem_write); end
   endtask

   task automatic test_ecall;
      do_reset();
      instr = 32'h00000073; in_valid = 1'b1;
      #1;
      total++; if (a_pc_load !== 1'b0) begin bad++;
         $display("FAIL ecall_pc_load got=%0b want=0", a_pc_load); end
      tick();
      instr = 32'h00A50533; resume = 1'b1;
      total++; if ({a_halted, a_paused, a_trap} !== 3'b100) begin bad++;
         $display("FAIL ecall_flags got=%b want=100", {a_halted, a_paused, a_trap}); end
      total++; if (a_retired !== 16'd1) begin bad++;
         $display("FAIL ecall_retired got=%0d want=1", a_retired); end
      tick();
      resume = 1'b0;
      total++; if ({a_ctrl_valid, a_bun} !== {1'b1, 10'b0}) begin bad++;
         $display("FAIL ecall_bundle got=%b want=1_0000000000", {a_ctrl_valid, a_bun}); end
      total++; if (a_halted !== 1'b1 || a_pc_load !== 1'b0) begin bad++;
         $display("FAIL ecall_hold got=h%0b p%0b want=h1 p0", a_halted, a_pc_load); end
      tick();
      total++; if (a_ctrl_valid !== 1'b0 || a_retired !== 16'd1) begin bad++;
         $display("FAIL ecall_ignore got=v%0b r%0d want=v0 r1", a_ctrl_valid, a_retired); end
      do_reset();
      #1;
      total++; if (a_halted !== 1'b0 || a_pc_load !== 1'b1) begin bad++;
         $display("FAIL ecall_rst got=h%0b p%0b want=h0 p1", a_halted, a_pc_load); end
   endtask

   task automatic test_ebreak;
      do_reset();
      instr = 32'h00100073; in_valid = 1'b1;
      #1;
      total++; if (a_pc_load !== 1'b0 || b_pc_load !== 1'b1) begin bad++;
         $display("FAIL ebreak_pc_load got=a%0b b%0b want=a0 b1", a_pc_load, b_pc_load); end
      tick();
      instr = 32'h00A50533;
      total++; if (a_paused !== 1'b1 || b_paused !== 1'b0) begin bad++;
         $display("FAIL ebreak_paused got=a%0b b%0b want=a1 b0", a_paused, b_paused); end
      total++; if ({b_ctrl_valid, b_bun} !== {1'b1, 10'b0}) begin bad++;
         $display("FAIL ebreak_b_nop got=%b want=1_0000000000", {b_ctrl_valid, b_bun}); end
      tick();
      in_valid = 1'b0; resume = 1'b1;
      total++; if (a_retired !== 16'd1 || b_retired !== 4'd2) begin bad++;
         $display("FAIL ebreak_retired got=a%0d b%0d want=a1 b2", a_retired, b_retired); end
      #1;
      total++; if (a_pc_load !== 1'b0) begin bad++;
         $display("FAIL pause_pc_load got=%0b want=0", a_pc_load); end
      tick();
      resume = 1'b0;
      #1;
      total++; if (a_paused !== 1'b0 || a_pc_load !== 1'b1) begin bad++;
         $display("FAIL resume got=q%0b p%0b want=q0 p1", a_paused, a_pc_load); end
   endtask

   task automatic test_illegal;
      do_reset();
      instr = 32'h0000007F; in_valid = 1'b1;
      #1;
      total++; if (a_pc_load !== 1'b0 || b_pc_load !== 1'b1) begin bad++;
         $display("FAIL illegal_pc_load got=a%0b b%0b want=a0 b1", a_pc_load, b_pc_load); end
      tick();
      instr = 32'h00000030; // OP opcode with bad low bits
      total++; if (a_trap !== 1'b1 || b_trap !== 1'b0) begin bad++;
         $display("FAIL illegal_trap got=a%0b b%0b want=a1 b0", a_trap, b_trap); end
      total++; if (b_ctrl_valid !== 1'b0 || b_bun !== 10'b0) begin bad++;
         $display("FAIL illegal_b_bubble got=%b want=0", {b_ctrl_valid, b_bun}); end
      tick();
      in_valid = 1'b0;
      total++; if (a_ctrl_valid !== 1'b0 || b_ctrl_valid !== 1'b0) begin bad++;
         $display("FAIL illegal_bubble got=a%0b b%0b want=a0 b0", a_ctrl_valid, b_ctrl_valid); end
      total++; if (a_retired !== 16'd1 || b_retired !== 4'd2) begin bad++;
         $display("FAIL illegal_retired got=a%0d b%0d want=a1 b2", a_retired, b_retired); end
      total++; if (a_trap !== 1'b1) begin bad++;
         $display("FAIL trap_sticky got=%0b want=1", a_trap); end
   endtask

   task automatic test_saturate;
      do_reset();
      instr = 32'h00A50533; in_valid = 1'b1;
      repeat (17) tick();
      in_valid = 1'b0;
      total++; if (b_retired !== 4'd15) begin bad++;
         $display("FAIL sat_b got=%0d want=15", b_retired); end
      total++; if (a_retired !== 16'd17) begin bad++;
         $display("FAIL sat_a got=%0d want=17", a_retired); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] vi [7];
      logic [9:0]  ve [7];
      vi[0] = 32'h000012B7; ve[0] = 10'b0_0_10_00_0_0_1_0; // LUI
      vi[1] = 32'h0000006F; ve[1] = 10'b1_0_01_00_0_0_1_1; // JAL
      vi[2] = 32'h00000063; ve[2] = 10'b1_0_00_01_0_1_0_0; // BEQ
      vi[3] = 32'h00008067; ve[3] = 10'b1_0_01_11_0_1_1_1; // JALR
      vi[4] = 32'h00000097; ve[4] = 10'b0_0_11_00_0_0_1_1; // AUIPC
      vi[5] = 32'h00150513; ve[5] = 10'b0_0_11_11_0_1_1_1; // ADDI
      vi[6] = 32'h0000000F; ve[6] = 10'b0;                 // FENCE
      do_reset();
      for (int i = 0; i < 8; i++) begin
         in_valid = (i < 7);
         instr = (i < 7) ? vi[i] : 32'h0;
         tick();
         if (i < 7) begin
            total++; if ({b_ctrl_valid, b_bun} !== {1'b1, ve[i]}) begin bad++;
               $display("FAIL b2b_b[%0d] got=%b want=1_%b", i, {b_ctrl_valid, b_bun}, ve[i]); end
         end
         if (i >= 1) begin
            total++; if ({a_ctrl_valid, a_bun} !== {1'b1, ve[i-1]}) begin bad++;
               $display("FAIL b2b_a[%0d] got=%b want=1_%b", i - 1, {a_ctrl_valid, a_bun},
                        ve[i-1]); end
         end
      end
      total++; if (a_retired !== 16'd7) begin bad++;
         $display("FAIL b2b_retired got=%0d want=7", a_retired); end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; instr = 32'h0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      resume = 1'b0;
      test_reset();
      test_add();
      test_load_stall();
      test_flush();
      test_ecall();
      test_ebreak();
      test_illegal();
      test_saturate();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
